// File: rtl/hazard_if.sv
// Hazard-unit port bundle: pipeline-side requests into the hazard controller and
// the per-stage bubble/flush steering it returns.
interface hazard_if;
  logic [4:0] rs1_D;
  logic [4:0] rs2_D;
  logic       rs1_used_D;
  logic       rs2_used_D;
  logic [4:0] rd_E;
  logic       mem_read_E;
  logic       redirect_E;
  logic       mem_req_M;
  logic       mem_ack;
  logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic       mem_err;

  modport master (
    output rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_E, mem_read_E,
           redirect_E, mem_req_M, mem_ack,
    input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushF, flushD, flushE, flushM, flushW, mem_err
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_E, mem_read_E,
           redirect_E, mem_req_M, mem_ack,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushF, flushD, flushE, flushM, flushW, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: data-memory wait/timeout FSM, load-use
// interlock and branch-redirect flushing, plus a stall performance counter.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_if.slave          hz,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] LIM = 8'(TIMEOUT);
  // Stage bit positions inside the bubble/flush vectors (F is the MSB).
  localparam int SF = 4, SD = 3, SE = 2, SM = 1, SW = 0;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [4:0]       w_bubble, w_flush;
  logic             w_ms, w_tmo, w_lu, w_at_lim, w_mem_err;

  assign w_at_lim = (r_wcnt == LIM);

  assign w_ms = ((r_state == IDLE) && hz.mem_req_M && !hz.mem_ack) ||
                ((r_state == MEM_WAIT) && !hz.mem_ack && !w_at_lim);

  assign w_tmo = (r_state == MEM_WAIT) && !hz.mem_ack && w_at_lim;

  assign w_lu = hz.mem_read_E && (hz.rd_E != 5'd0) &&
                ((hz.rs1_used_D && (hz.rs1_D == hz.rd_E)) ||
                 (hz.rs2_used_D && (hz.rs2_D == hz.rd_E)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      IDLE: begin
        if (hz.mem_req_M && !hz.mem_ack) begin
          w_state_nxt = MEM_WAIT;
          w_wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ack || w_at_lim) begin
          w_state_nxt = IDLE;
          w_wcnt_nxt  = 8'd0;
        end else begin
          w_wcnt_nxt = r_wcnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // A redirect that arrives during a memory stall stays in E, so it is simply
  // picked up by the redirect branch once the stall condition drops.
  always_comb begin
    w_bubble  = 5'b00000;
    w_flush   = 5'b00000;
    w_mem_err = 1'b0;
    if (!rst_n) begin
      w_flush = 5'b11111;
    end else if (w_ms) begin
      w_bubble[SF] = 1'b1;
      w_bubble[SD] = 1'b1;
      w_bubble[SE] = 1'b1;
      w_bubble[SM] = 1'b1;
      w_flush[SW]  = 1'b1;
    end else if (w_tmo) begin
      w_mem_err   = 1'b1;
      w_flush[SM] = 1'b1;
    end else if (hz.redirect_E) begin
      w_flush[SD] = 1'b1;
      w_flush[SE] = 1'b1;
    end else if (w_lu) begin
      w_bubble[SF] = 1'b1;
      w_bubble[SD] = 1'b1;
      w_flush[SE]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_stall_cnt <= '0;
    else if (w_bubble[SF]) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign hz.bubbleF = w_bubble[SF];
  assign hz.bubbleD = w_bubble[SD];
  assign hz.bubbleE = w_bubble[SE];
  assign hz.bubbleM = w_bubble[SM];
  assign hz.bubbleW = w_bubble[SW];
  assign hz.flushF  = w_flush[SF];
  assign hz.flushD  = w_flush[SD];
  assign hz.flushE  = w_flush[SE];
  assign hz.flushM  = w_flush[SM];
  assign hz.flushW  = w_flush[SW];
  assign hz.mem_err = w_mem_err;
  assign stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with TIMEOUT=4 and an 8-bit stall counter.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] stall_cnt;
  int         errors = 0;
  int         checks = 0;

  hazard_if hz();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hz        (hz),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vectors are {F,D,E,M,W}.
  task automatic ctl(input string tag, input logic [4:0] b, input logic [4:0] f, input logic e);
    #1;
    chk({tag, ".bubble"}, 32'({hz.bubbleF, hz.bubbleD, hz.bubbleE, hz.bubbleM, hz.bubbleW}), 32'(b));
    chk({tag, ".flush"},  32'({hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW}), 32'(f));
    chk({tag, ".mem_err"}, 32'(hz.mem_err), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lu(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                    input logic [4:0] r2, input logic u2);
    hz.mem_read_E = mr; hz.rd_E = rd;
    hz.rs1_D = r1; hz.rs1_used_D = u1;
    hz.rs2_D = r2; hz.rs2_used_D = u2;
  endtask

  task automatic mem(input logic req, input logic ack, input logic redir);
    hz.mem_req_M = req; hz.mem_ack = ack; hz.redirect_E = redir;
  endtask

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] MSB  = 5'b11110;
  localparam logic [4:0] MSF  = 5'b00001;
  localparam logic [4:0] LUB  = 5'b11000;
  localparam logic [4:0] LUF  = 5'b00100;
  localparam logic [4:0] RDF  = 5'b01100;

  initial begin
    lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    mem(1'b0, 1'b0, 1'b0);

    // Reset state
    ctl("reset", NONE, 5'b11111, 1'b0);
    chk("reset.cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    ctl("idle", NONE, NONE, 1'b0);

    // Load-use on rs1
    lu(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ctl("lu_rs1", LUB, LUF, 1'b0);
    tick();
    lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    ctl("lu_after", NONE, NONE, 1'b0);
    chk("lu.cnt", 32'(stall_cnt), 32'd1);

    // rd_E = x0 never interlocks
    lu(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    ctl("lu_x0", NONE, NONE, 1'b0);
    tick();

    // rs2 match, then same with rs2 unused
    lu(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    ctl("lu_rs2", LUB, LUF, 1'b0);
    tick();
    lu(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
    ctl("lu_rs2_unused", NONE, NONE, 1'b0);
    tick();
    lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("lu2.cnt", 32'(stall_cnt), 32'd2);

    // Memory ack three cycles after request
    mem(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ctl($sformatf("wait3_%0d", i), MSB, MSF, 1'b0);
      tick();
    end
    mem(1'b1, 1'b1, 1'b0);
    ctl("wait3_ack", NONE, NONE, 1'b0);
    tick();
    chk("wait3.cnt", 32'(stall_cnt), 32'd5);

    // Zero-wait access from IDLE
    ctl("zero_wait", NONE, NONE, 1'b0);
    tick();
    mem(1'b0, 1'b0, 1'b0);
    ctl("zero_wait_after", NONE, NONE, 1'b0);
    chk("zero_wait.cnt", 32'(stall_cnt), 32'd5);

    // Timeout: 4 stall cycles then a single mem_err/flushM cycle
    mem(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ctl($sformatf("tmo_stall_%0d", i), MSB, MSF, 1'b0);
      tick();
    end
    ctl("tmo_err", NONE, 5'b00010, 1'b1);
    tick();
    mem(1'b0, 1'b0, 1'b0);
    ctl("tmo_after", NONE, NONE, 1'b0);
    chk("tmo.cnt", 32'(stall_cnt), 32'd9);

    // Redirect beats load-use
    lu(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    mem(1'b0, 1'b0, 1'b1);
    ctl("redir_lu", NONE, RDF, 1'b0);
    tick();
    lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("redir.cnt", 32'(stall_cnt), 32'd9);

    // Redirect held during memory wait takes effect once acked
    mem(1'b1, 1'b0, 1'b1);
    ctl("redir_ms", MSB, MSF, 1'b0);
    tick();
    mem(1'b1, 1'b1, 1'b1);
    ctl("redir_ack", NONE, RDF, 1'b0);
    tick();
    mem(1'b0, 1'b0, 1'b0);
    ctl("redir_done", NONE, NONE, 1'b0);
    chk("redir_ms.cnt", 32'(stall_cnt), 32'd10);

    // Reset asserted mid-wait
    mem(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("rstw.cnt_pre", 32'(stall_cnt), 32'd12);
    #2;
    rst_n = 1'b0;
    mem(1'b0, 1'b0, 1'b0);
    ctl("rstw", NONE, 5'b11111, 1'b0);
    chk("rstw.cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    ctl("rstw_idle", NONE, NONE, 1'b0);
    tick();
    // A fresh wait must time out after the full 4 stall cycles again
    mem(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ctl($sformatf("rstw_stall_%0d", i), MSB, MSF, 1'b0);
      tick();
    end
    ctl("rstw_tmo", NONE, 5'b00010, 1'b1);
    tick();
    mem(1'b0, 1'b0, 1'b0);
    chk("rstw.cnt_post", 32'(stall_cnt), 32'd4);

    // Counter wrap: 251 more stalls reaches 255, one more wraps to 0
    lu(1'b1, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 251; i++) tick();
    chk("wrap.255", 32'(stall_cnt), 32'd255);
    tick();
    chk("wrap.0", 32'(stall_cnt), 32'd0);
    lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("wrap.hold", 32'(stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
